kmc_memarb: RTL and testbench
=============================

KMC_MEMARB -- requirements
Module: kmc_memarb

Interface
REQ-001 SHALL provide: clk  in  1  single system clock; all state on rising edge.
REQ-002 SHALL provide: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: kmcINIT  in  1  synchronous KMC initialize.
REQ-004 SHALL provide: cpuREQ  in  1  microsequencer memory access this cycle (MOV with MEMCLKEN).
REQ-005 SHALL provide: cpuWR  in  1  microsequencer write qualifier.
REQ-006 SHALL provide: cpuADDR  in  10  microsequencer address (MAR[9:0]).
REQ-007 SHALL provide: cpuDATA  in  8  microsequencer write data (ALU).
REQ-008 SHALL provide: cpuSTALL  out  1  microsequencer must not advance this cycle.
REQ-009 SHALL provide: hostREQ, hostWR  in  1 each  host/maintenance request and write qualifier.
REQ-010 SHALL provide: hostADDR  in  10, hostDATA  in  8  host address and write data.
REQ-011 SHALL provide: hostACK  out  1, hostRDDATA  out  8  completion pulse and read data.
REQ-012 SHALL provide: ramADDR  out  10, ramWE  out  1, ramWDATA  out  8  single RAM port.
REQ-013 SHALL provide: ramRDATA  in  8  RAM read data, valid one cycle after address.

Function
REQ-014 SHALL implement states IDLE, HWR, HRD, HCAP, HACK.
REQ-015 In IDLE, cpuREQ=1 (and no stall) SHALL give the CPU the port: ramADDR=cpuADDR, ramWE=cpuWR, ramWDATA=cpuDATA; state stays IDLE.
REQ-016 In IDLE with cpuREQ=0 and hostREQ=1, host SHALL be granted that cycle: ramADDR=hostADDR, ramWE=hostWR, ramWDATA=hostDATA; next state HWR if hostWR else HRD.
REQ-017 When no owner, ramADDR SHALL default to cpuADDR with ramWE=0.
REQ-018 HWR SHALL last one cycle with port returned to CPU, then go to HACK; write occurs in grant cycle N, hostACK=1 in N+2.
REQ-019 HRD (N+1) SHALL capture ramRDATA into hostRDDATA at end of cycle; HCAP is removed: read ACK SHALL be in N+2 via HACK; CPU owns port during HRD.
REQ-020 HACK SHALL assert hostACK for exactly one cycle, then return to IDLE; hostREQ still high in the following IDLE SHALL be treated as a new request.
REQ-021 Host SHALL be granted only from IDLE; hostRDDATA SHALL hold its value until the next host read capture.
REQ-022 Write-then-read of same address by CPU then host in consecutive cycles SHALL return the new data.
REQ-023 kmcINIT SHALL force IDLE next cycle, suppress any pending hostACK, and clear the wait counter; a write already issued is not undone.
REQ-024 cpuSTALL SHALL be 0 except as in REQ-030.

Reset
REQ-025 On rst: state=IDLE, hostACK=0, hostRDDATA=8'h00, wait counter=0, cpuSTALL=0.
REQ-026 rst mid-transaction SHALL abort with no hostACK; outputs SHALL reach reset values asynchronously.

Configuration
REQ-027 Macro KMC_MEMARB_TIMEOUT_EN SHALL select starvation protection.
REQ-028 With it: 4-bit wait counter SHALL increment each IDLE cycle where hostREQ=1 and host not granted, saturating at 15.
REQ-029 Counter SHALL clear on host grant, kmcINIT, or hostREQ=0.
REQ-030 With it, at count 15 in IDLE: cpuSTALL=1 for that cycle and host granted regardless of cpuREQ.
REQ-031 Without it: no counter, cpuSTALL tied 0, host may starve indefinitely.

Structure
REQ-032 State enum and timeout limit (15) SHALL live in shared package kmc_memarb_pkg.
REQ-033 Wait counter SHALL be sub-module kmc_arbtmr, instantiated only with KMC_MEMARB_TIMEOUT_EN.
REQ-034 RAM array SHALL be external; block contains no storage array.

Verification
REQ-035 Idle CPU, host write addr 10'h155 data 8'hA5 -> ramWE=1 with 10'h155/8'hA5 in N, hostACK in N+2.
REQ-036 Then host read 10'h155 -> hostACK in N+2, hostRDDATA=8'hA5.
REQ-037 cpuREQ=1 continuously, hostREQ=1: without macro no hostACK in 100 cycles; with macro cpuSTALL in 16th cycle, host granted, hostACK two cycles later.
REQ-038 Host read in flight, kmcINIT in HRD -> IDLE next cycle, no hostACK.
REQ-039 rst asserted in HACK -> hostACK drops immediately, hostRDDATA=8'h00.
REQ-040 CPU write 10'h3FF=8'h5A, host read 10'h3FF next cycle -> hostRDDATA=8'h5A.

Source files
------------

// File: rtl/kmc_memarb_pkg.sv
// rtl/kmc_memarb_pkg.sv - shared state encodings, timeout limit and RAM command type for the KMC memory arbiter
package kmc_memarb_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HWR  = 3'd1;
    localparam logic [2:0] ST_HRD  = 3'd2;
    // HCAP keeps its historical encoding but is never entered; read data is captured in HRD.
    localparam logic [2:0] ST_HCAP = 3'd3;
    localparam logic [2:0] ST_HACK = 3'd4;

    localparam logic [3:0] WAIT_LIMIT = 4'd15;

    typedef struct packed {
        logic [9:0] addr;
        logic       we;
        logic [7:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/kmc_arbtmr.sv
// rtl/kmc_arbtmr.sv - saturating host wait counter used for starvation protection
module kmc_arbtmr
    import kmc_memarb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && (count != WAIT_LIMIT)) begin
            count <= count + 4'd1;
        end
    end

    assign at_limit = (count == WAIT_LIMIT);

endmodule

// File: rtl/kmc_memarb.sv
// rtl/kmc_memarb.sv - single-port RAM arbiter between KMC microsequencer and host; KMC_MEMARB_TIMEOUT_EN enables starvation protection
module kmc_memarb
    import kmc_memarb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       kmcINIT,
    input  logic       cpuREQ,
    input  logic       cpuWR,
    input  logic [9:0] cpuADDR,
    input  logic [7:0] cpuDATA,
    output logic       cpuSTALL,
    input  logic       hostREQ,
    input  logic       hostWR,
    input  logic [9:0] hostADDR,
    input  logic [7:0] hostDATA,
    output logic       hostACK,
    output logic [7:0] hostRDDATA,
    output logic [9:0] ramADDR,
    output logic       ramWE,
    output logic [7:0] ramWDATA,
    input  logic [7:0] ramRDATA
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       is_idle;
    logic       stall_req;
    logic       host_grant;
    ram_cmd_t   ram_cmd;

    assign is_idle = (state == ST_IDLE);

`ifdef KMC_MEMARB_TIMEOUT_EN
    logic tmr_clr;
    logic tmr_inc;
    logic at_limit;

    assign tmr_clr = host_grant | kmcINIT | ~hostREQ;
    assign tmr_inc = is_idle & hostREQ & ~host_grant;

    kmc_arbtmr u_arbtmr (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .inc      (tmr_inc),
        .at_limit (at_limit)
    );

    assign stall_req = is_idle & hostREQ & at_limit & ~kmcINIT;
`else
    assign stall_req = 1'b0;
`endif

    // Host is only ever granted from IDLE; an init cycle never starts a new transaction.
    assign host_grant = is_idle & hostREQ & ~kmcINIT & (~cpuREQ | stall_req);

    always_comb begin
        ram_cmd.addr  = cpuADDR;
        ram_cmd.we    = cpuREQ & cpuWR;
        ram_cmd.wdata = cpuDATA;
        if (host_grant) begin
            ram_cmd.addr  = hostADDR;
            ram_cmd.we    = hostWR;
            ram_cmd.wdata = hostDATA;
        end
    end

    assign ramADDR  = ram_cmd.addr;
    assign ramWE    = ram_cmd.we;
    assign ramWDATA = ram_cmd.wdata;

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (host_grant) begin
                    state_next = hostWR ? ST_HWR : ST_HRD;
                end
            end
            ST_HWR:  state_next = ST_HACK;
            ST_HRD:  state_next = ST_HACK;
            ST_HACK: state_next = ST_IDLE;
            ST_HCAP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (kmcINIT) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RAM read data for the grant-cycle address arrives during HRD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hostRDDATA <= 8'h00;
        end else if ((state == ST_HRD) && !kmcINIT) begin
            hostRDDATA <= ramRDATA;
        end
    end

    assign hostACK  = (state == ST_HACK);
    assign cpuSTALL = stall_req;

endmodule

// File: tb/tb_kmc_memarb.sv
// tb/tb_kmc_memarb.sv - directed self-checking bench for kmc_memarb with an external RAM model
module tb_kmc_memarb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kmcINIT = 1'b0;
    logic       cpuREQ = 1'b0;
    logic       cpuWR = 1'b0;
    logic [9:0] cpuADDR = 10'h000;
    logic [7:0] cpuDATA = 8'h00;
    logic       cpuSTALL;
    logic       hostREQ = 1'b0;
    logic       hostWR = 1'b0;
    logic [9:0] hostADDR = 10'h000;
    logic [7:0] hostDATA = 8'h00;
    logic       hostACK;
    logic [7:0] hostRDDATA;
    logic [9:0] ramADDR;
    logic       ramWE;
    logic [7:0] ramWDATA;
    logic [7:0] ramRDATA = 8'h00;

    logic [7:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    kmc_memarb dut (
        .clk        (clk),
        .rst        (rst),
        .kmcINIT    (kmcINIT),
        .cpuREQ     (cpuREQ),
        .cpuWR      (cpuWR),
        .cpuADDR    (cpuADDR),
        .cpuDATA    (cpuDATA),
        .cpuSTALL   (cpuSTALL),
        .hostREQ    (hostREQ),
        .hostWR     (hostWR),
        .hostADDR   (hostADDR),
        .hostDATA   (hostDATA),
        .hostACK    (hostACK),
        .hostRDDATA (hostRDDATA),
        .ramADDR    (ramADDR),
        .ramWE      (ramWE),
        .ramWDATA   (ramWDATA),
        .ramRDATA   (ramRDATA)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramWE) mem[ramADDR] <= ramWDATA;
        ramRDATA <= mem[ramADDR];
    end

    typedef struct {
        logic       c_req;
        logic       c_wr;
        logic [9:0] c_addr;
        logic [7:0] c_data;
        logic       h_req;
        logic [9:0] h_addr;
        logic [9:0] e_addr;
        logic       e_we;
        logic [7:0] e_wdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_inputs();
        kmcINIT = 1'b0;
        cpuREQ  = 1'b0;
        cpuWR   = 1'b0;
        hostREQ = 1'b0;
        hostWR  = 1'b0;
    endtask

    initial begin
        int first_stall;
        int first_ack;
        int ack_count;
        int stall_count;
        logic [9:0] grant_addr;
        logic       grant_we;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        vecs[0] = '{1'b1, 1'b1, 10'h012, 8'h34, 1'b0, 10'h000, 10'h012, 1'b1, 8'h34};
        vecs[1] = '{1'b1, 1'b0, 10'h2AB, 8'hFF, 1'b0, 10'h000, 10'h2AB, 1'b0, 8'hFF};
        vecs[2] = '{1'b0, 1'b1, 10'h100, 8'h77, 1'b0, 10'h000, 10'h100, 1'b0, 8'h77};
        vecs[3] = '{1'b1, 1'b1, 10'h3FF, 8'h00, 1'b0, 10'h000, 10'h3FF, 1'b1, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 10'h000, 8'hC3, 1'b0, 10'h000, 10'h000, 1'b0, 8'hC3};
        vecs[5] = '{1'b1, 1'b0, 10'h055, 8'h11, 1'b1, 10'h2AA, 10'h055, 1'b0, 8'h11};

        // reset state
        #12;
        chk("reset_ack", hostACK, 1'b0);
        chk("reset_rddata", hostRDDATA, 8'h00);
        chk("reset_stall", cpuSTALL, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // idle port ownership table
        for (int i = 0; i < 6; i++) begin
            cpuREQ   = vecs[i].c_req;
            cpuWR    = vecs[i].c_wr;
            cpuADDR  = vecs[i].c_addr;
            cpuDATA  = vecs[i].c_data;
            hostREQ  = vecs[i].h_req;
            hostADDR = vecs[i].h_addr;
            #2;
            chk($sformatf("vec%0d_addr", i), ramADDR, vecs[i].e_addr);
            chk($sformatf("vec%0d_we", i), ramWE, vecs[i].e_we);
            chk($sformatf("vec%0d_wdata", i), ramWDATA, vecs[i].e_wdata);
            chk($sformatf("vec%0d_stall", i), cpuSTALL, 1'b0);
            chk($sformatf("vec%0d_ack", i), hostACK, 1'b0);
            tick();
        end
        set_idle_inputs();
        tick();

        // host write 155 = A5
        hostREQ = 1'b1; hostWR = 1'b1; hostADDR = 10'h155; hostDATA = 8'hA5;
        cpuADDR = 10'h001;
        #2;
        chk("wr_N_we", ramWE, 1'b1);
        chk("wr_N_addr", ramADDR, 10'h155);
        chk("wr_N_data", ramWDATA, 8'hA5);
        chk("wr_N_ack", hostACK, 1'b0);
        tick();
        hostREQ = 1'b0;
        #2;
        chk("wr_N1_ack", hostACK, 1'b0);
        chk("wr_N1_addr", ramADDR, 10'h001);
        tick();
        chk("wr_N2_ack", hostACK, 1'b1);
        tick();
        chk("wr_N3_ack", hostACK, 1'b0);

        // host read 155
        hostREQ = 1'b1; hostWR = 1'b0; hostADDR = 10'h155;
        #2;
        chk("rd_N_addr", ramADDR, 10'h155);
        chk("rd_N_we", ramWE, 1'b0);
        tick();
        hostREQ = 1'b0;
        #2;
        chk("rd_N1_ack", hostACK, 1'b0);
        tick();
        chk("rd_N2_ack", hostACK, 1'b1);
        chk("rd_N2_data", hostRDDATA, 8'hA5);
        tick();
        chk("rd_N3_ack", hostACK, 1'b0);
        tick();
        chk("rd_hold_data", hostRDDATA, 8'hA5);

        // CPU write 3FF then host read next cycle
        cpuREQ = 1'b1; cpuWR = 1'b1; cpuADDR = 10'h3FF; cpuDATA = 8'h5A;
        tick();
        cpuREQ = 1'b0; cpuWR = 1'b0;
        hostREQ = 1'b1; hostWR = 1'b0; hostADDR = 10'h3FF;
        tick();
        hostREQ = 1'b0;
        tick();
        chk("wtr_ack", hostACK, 1'b1);
        chk("wtr_data", hostRDDATA, 8'h5A);
        tick();

        // kmcINIT during HRD kills the read
        hostREQ = 1'b1; hostWR = 1'b0; hostADDR = 10'h155;
        tick();
        hostREQ = 1'b0; kmcINIT = 1'b1;
        tick();
        kmcINIT = 1'b0;
        hostREQ = 1'b1; hostWR = 1'b1; hostADDR = 10'h0C0; hostDATA = 8'h3C;
        cpuADDR = 10'h002;
        #2;
        chk("init_no_ack", hostACK, 1'b0);
        chk("init_idle_grant_addr", ramADDR, 10'h0C0);
        chk("init_idle_grant_we", ramWE, 1'b1);
        tick();
        hostREQ = 1'b0;
        #2;
        chk("init_post_ack0", hostACK, 1'b0);
        tick();
        chk("init_post_ack1", hostACK, 1'b1);

        // asynchronous reset in HACK
        #2 rst = 1'b1;
        #1;
        chk("rst_hack_ack", hostACK, 1'b0);
        chk("rst_hack_rddata", hostRDDATA, 8'h00);
        chk("rst_hack_stall", cpuSTALL, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        set_idle_inputs();
        tick();

        // CPU hogs the port while host waits
        cpuREQ = 1'b1; cpuWR = 1'b0; cpuADDR = 10'h033;
        hostREQ = 1'b1; hostWR = 1'b0; hostADDR = 10'h2AA;
        first_stall = 0; first_ack = 0; ack_count = 0; stall_count = 0;
        grant_addr = 10'h000; grant_we = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            #2;
            if (cpuSTALL) begin
                stall_count++;
                if (first_stall == 0) begin
                    first_stall = c;
                    grant_addr = ramADDR;
                    grant_we = ramWE;
                end
            end
            if (hostACK) begin
                ack_count++;
                if (first_ack == 0) first_ack = c;
            end
            tick();
        end
`ifdef KMC_MEMARB_TIMEOUT_EN
        chk("starve_first_stall", first_stall, 16);
        chk("starve_grant_addr", grant_addr, 10'h2AA);
        chk("starve_grant_we", grant_we, 1'b0);
        chk("starve_first_ack", first_ack, 18);
`else
        chk("starve_ack_count", ack_count, 0);
        chk("starve_stall_count", stall_count, 0);
`endif
        set_idle_inputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
